// File: rtl/rx_frame_pkg.sv
// Shared descriptor layout and FSM state encoding for the RX frame reader.
package rx_frame_pkg;

  localparam int DESC_W   = 20;
  localparam int LEN_LSB  = 0;
  localparam int LEN_W    = 12;
  localparam int PRIO_LSB = 16;
  localparam int PRIO_W   = 3;
  localparam int ERR_BIT  = 19;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PLAT = 3'd1;
  localparam logic [2:0] PASS = 3'd2;
  localparam logic [2:0] DROP = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  typedef struct packed {
    logic              err;
    logic [PRIO_W-1:0] prio;
    logic [LEN_W-1:0]  len;
  } desc_t;

  // Reserved bits [15:12] are deliberately not extracted.
  function automatic desc_t unpack_desc(input logic [DESC_W-1:0] raw);
    desc_t d;
    d.len  = raw[LEN_LSB +: LEN_W];
    d.prio = raw[PRIO_LSB +: PRIO_W];
    d.err  = raw[ERR_BIT];
    return d;
  endfunction

endpackage

// File: rtl/frame_skid_buf.sv
// Two-entry ready/valid buffer for frame bytes plus sof/eof tags.
// The writer is expected to respect the occupancy output and never push
// into a full buffer.
module frame_skid_buf (
  input  logic       clk,
  input  logic       rst_sys,
  input  logic       in_valid,
  input  logic [9:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [9:0] out_data,
  output logic [1:0] occ
);

  logic [9:0] mem0;
  logic [9:0] mem1;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       pop;

  assign pop       = out_valid && out_ready;
  assign out_valid = (count != 2'd0);
  assign out_data  = rd_ptr ? mem1 : mem0;
  assign occ       = count;

  // Storage, pointers and occupancy; push and pop may happen together.
  always_ff @(posedge clk) begin
    if (rst_sys) begin
      mem0   <= '0;
      mem1   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (in_valid) begin
        if (wr_ptr) mem1 <= in_data;
        else        mem0 <= in_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, in_valid} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/rx_frame_reader.sv
// Reads descriptors and frame bytes from one MAC port's RX FIFOs and
// presents good frames as a ready/valid byte stream; bad frames are drained.
//
// state | meaning
// IDLE  | waiting for a descriptor; pops one when available
// PLAT  | descriptor on ptr_fifo_dout; latch it, issue first byte read
// PASS  | reading bytes into the skid buffer, delivering downstream
// DROP  | reading and discarding bytes of a bad frame
// DONE  | bump pass/drop counter, then back to IDLE
module rx_frame_reader
  import rx_frame_pkg::*;
#(
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_sys,
  output logic             ptr_fifo_rd,
  input  logic [19:0]      ptr_fifo_dout,
  input  logic             ptr_fifo_empty,
  output logic             data_fifo_rd,
  input  logic [7:0]       data_fifo_dout,
  output logic             frm_valid,
  input  logic             frm_ready,
  output logic [7:0]       frm_data,
  output logic             frm_sof,
  output logic             frm_eof,
  output logic [11:0]      frm_len,
  output logic [2:0]       frm_prio,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_pass,
  output logic [CNT_W-1:0] cnt_drop
);

  localparam logic [LEN_W:0] MAX_LEN_C = (LEN_W+1)'(MAX_LEN);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [LEN_W-1:0] len_r;
  logic [2:0]       prio_r;
  logic             drop_r;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] push_idx;
  logic             rd_d;
  desc_t            desc_in;
  logic             desc_bad;
  logic             sk_push;
  logic [9:0]       sk_in_data;
  logic [9:0]       sk_out_data;
  logic [1:0]       sk_occ;
  logic             pop;
  logic             credit_ok;

  assign desc_in  = unpack_desc(ptr_fifo_dout);
  assign desc_bad = desc_in.err || (desc_in.len == '0) ||
                    ({1'b0, desc_in.len} > MAX_LEN_C);

  // A byte read last cycle is on data_fifo_dout now; only good frames keep it.
  assign sk_push    = rd_d && (state == PASS);
  assign sk_in_data = {(push_idx == '0), (push_idx == len_r - 12'd1), data_fifo_dout};

  frame_skid_buf u_skid (
    .clk       (clk),
    .rst_sys   (rst_sys),
    .in_valid  (sk_push),
    .in_data   (sk_in_data),
    .out_valid (frm_valid),
    .out_ready (frm_ready),
    .out_data  (sk_out_data),
    .occ       (sk_occ)
  );

  assign frm_sof  = sk_out_data[9];
  assign frm_eof  = sk_out_data[8];
  assign frm_data = sk_out_data[7:0];
  assign frm_len  = len_r;
  assign frm_prio = prio_r;
  assign busy     = (state != IDLE);
  assign pop      = frm_valid && frm_ready;

  // A byte leaving this cycle frees its slot in time for a new read, which
  // keeps one byte per clock flowing with frm_ready held high.
  assign credit_ok = ({1'b0, sk_occ} + {2'b0, rd_d}) < (3'd2 + {2'b0, pop});

  // Next-state and FIFO read strobes.
  always_comb begin
    state_nxt    = state;
    ptr_fifo_rd  = 1'b0;
    data_fifo_rd = 1'b0;
    case (state)
      IDLE: begin
        if (!ptr_fifo_empty) begin
          ptr_fifo_rd = 1'b1;
          state_nxt   = PLAT;
        end
      end
      PLAT: begin
        data_fifo_rd = (desc_in.len != '0);
        if (desc_in.len == '0) state_nxt = DONE;
        else if (desc_bad)     state_nxt = DROP;
        else                   state_nxt = PASS;
      end
      PASS: begin
        data_fifo_rd = (rem != '0) && credit_ok;
        if ((rem == '0) && pop && frm_eof) state_nxt = DONE;
      end
      DROP: begin
        data_fifo_rd = (rem != '0);
        if (rem == '0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, descriptor latch, byte bookkeeping and saturating statistics.
  always_ff @(posedge clk) begin
    if (rst_sys) begin
      state    <= IDLE;
      len_r    <= '0;
      prio_r   <= '0;
      drop_r   <= 1'b0;
      rem      <= '0;
      push_idx <= '0;
      rd_d     <= 1'b0;
      cnt_pass <= '0;
      cnt_drop <= '0;
    end else begin
      state <= state_nxt;
      rd_d  <= data_fifo_rd;
      if (state == PLAT) begin
        len_r    <= desc_in.len;
        prio_r   <= desc_in.prio;
        drop_r   <= desc_bad;
        rem      <= desc_in.len - {{(LEN_W-1){1'b0}}, data_fifo_rd};
        push_idx <= '0;
      end else begin
        if (data_fifo_rd) rem <= rem - 12'd1;
        if (sk_push) push_idx <= push_idx + 12'd1;
      end
      if (state == DONE) begin
        if (drop_r) begin
          if (cnt_drop != '1) cnt_drop <= cnt_drop + 1'b1;
        end else begin
          if (cnt_pass != '1) cnt_pass <= cnt_pass + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_reader.sv
// Directed and randomized bench for rx_frame_reader with FIFO models and a
// byte-stream scoreboard built from the descriptor rules.
module tb_rx_frame_reader;

  localparam int MAX_LEN = 1518;

  logic        clk = 1'b0;
  logic        rst_sys = 1'b1;
  logic        ptr_fifo_rd;
  logic [19:0] ptr_fifo_dout = '0;
  logic        ptr_fifo_empty = 1'b1;
  logic        data_fifo_rd;
  logic [7:0]  data_fifo_dout = '0;
  logic        frm_valid;
  logic        frm_ready = 1'b0;
  logic [7:0]  frm_data;
  logic        frm_sof;
  logic        frm_eof;
  logic [11:0] frm_len;
  logic [2:0]  frm_prio;
  logic        busy;
  logic [15:0] cnt_pass;
  logic [15:0] cnt_drop;

  always #5 clk = ~clk;

  rx_frame_reader #(.MAX_LEN(MAX_LEN), .CNT_W(16)) dut (
    .clk            (clk),
    .rst_sys        (rst_sys),
    .ptr_fifo_rd    (ptr_fifo_rd),
    .ptr_fifo_dout  (ptr_fifo_dout),
    .ptr_fifo_empty (ptr_fifo_empty),
    .data_fifo_rd   (data_fifo_rd),
    .data_fifo_dout (data_fifo_dout),
    .frm_valid      (frm_valid),
    .frm_ready      (frm_ready),
    .frm_data       (frm_data),
    .frm_sof        (frm_sof),
    .frm_eof        (frm_eof),
    .frm_len        (frm_len),
    .frm_prio       (frm_prio),
    .busy           (busy),
    .cnt_pass       (cnt_pass),
    .cnt_drop       (cnt_drop)
  );

  typedef struct packed {
    logic [7:0]  data;
    logic        sof;
    logic        eof;
    logic [11:0] len;
    logic [2:0]  prio;
  } exp_t;

  logic [19:0] ptr_q[$];
  logic [7:0]  data_q[$];
  exp_t        exp_q[$];

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc_n = 0, pop_cyc = 0;
  int rd_tot = 0, acc_tot = 0, valid_tot = 0;
  int exp_pass = 0, exp_drop = 0;
  int ready_mode = 0, pat_i = 0;
  bit ost_on = 0;
  logic ptr_rd_s = 0, data_rd_s = 0, prev_stall = 0;
  logic [9:0] prev_out = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Queue one frame: bytes into the data FIFO, descriptor into the pointer
  // FIFO, and, for deliverable frames, the expected byte stream.
  task automatic load_frame(input bit err, input int prio, input int len, input int rsv);
    logic [7:0] b;
    bit good;
    good = !err && (len != 0) && (len <= MAX_LEN);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      data_q.push_back(b);
      if (good) exp_q.push_back({b, (i == 0), (i == len - 1), 12'(len), 3'(prio)});
    end
    if (good) exp_pass++; else exp_drop++;
    ptr_q.push_back({err, 3'(prio), 4'(rsv), 12'(len)});
  endtask

  // One clock: FIFO models react just after the edge, then outputs are
  // sampled and scored at the falling edge.
  task automatic cycle();
    exp_t e;
    @(posedge clk); #1;
    cyc_n++;
    if (ptr_rd_s) begin
      chk("ptr_pop_nonempty", (ptr_q.size() != 0), 1);
      if (ptr_q.size() != 0) ptr_fifo_dout = ptr_q.pop_front();
    end
    if (data_rd_s) begin
      chk("data_pop_nonempty", (data_q.size() != 0), 1);
      if (data_q.size() != 0) data_fifo_dout = data_q.pop_front();
    end
    ptr_fifo_empty = (ptr_q.size() == 0);
    case (ready_mode)
      0: frm_ready = 1'b1;
      1: begin frm_ready = ((pat_i % 4) == 0) || ((pat_i % 4) == 3); pat_i++; end
      default: frm_ready = ($urandom_range(3) != 0);
    endcase
    @(negedge clk);
    ptr_rd_s  = ptr_fifo_rd;
    data_rd_s = data_fifo_rd;
    if (ptr_fifo_rd) pop_cyc = cyc_n;
    if (data_fifo_rd) rd_tot++;
    if (frm_valid) valid_tot++;
    if (prev_stall) begin
      chk("hold_valid", frm_valid, 1);
      chk("hold_bus", {frm_sof, frm_eof, frm_data}, prev_out);
    end
    prev_stall = frm_valid && !frm_ready;
    prev_out   = {frm_sof, frm_eof, frm_data};
    if (frm_valid && frm_ready) begin
      acc_tot++;
      chk("byte_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("data", frm_data, e.data);
        chk("sof", frm_sof, e.sof);
        chk("eof", frm_eof, e.eof);
        chk("len", frm_len, e.len);
        chk("prio", frm_prio, e.prio);
      end
    end
    if (ost_on) chk("outstanding_le2", ((rd_tot - acc_tot) <= 2), 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!((ptr_q.size() == 0) && !busy && !ptr_rd_s) && (n < budget));
    chk({tag, "_done_in_time"}, (n < budget), 1);
    chk({tag, "_stream_complete"}, exp_q.size(), 0);
    chk({tag, "_data_drained"}, data_q.size(), 0);
    chk({tag, "_cnt_pass"}, cnt_pass, exp_pass);
    chk({tag, "_cnt_drop"}, cnt_drop, exp_drop);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_sys = 1'b1;
    frm_ready = 1'b0;
    ptr_q.delete(); data_q.delete(); exp_q.delete();
    ptr_fifo_empty = 1'b1;
    ptr_fifo_dout = '0;
    data_fifo_dout = '0;
    @(posedge clk); #1;
    rst_sys = 1'b0;
    @(negedge clk);
    ptr_rd_s = ptr_fifo_rd;
    data_rd_s = data_fifo_rd;
    prev_stall = 1'b0;
    exp_pass = 0;
    exp_drop = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ptr_rd"}, ptr_fifo_rd, 0);
    chk({tag, "_data_rd"}, data_fifo_rd, 0);
    chk({tag, "_valid"}, frm_valid, 0);
    chk({tag, "_bus"}, {frm_sof, frm_eof, frm_data, frm_len, frm_prio}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cnt_pass"}, cnt_pass, 0);
    chk({tag, "_cnt_drop"}, cnt_drop, 0);
  endtask

  initial begin
    int n;
    pulse_reset();
    pulse_reset();
    check_zero("reset");

    // Single 64-byte frame with first-byte latency
    ready_mode = 0;
    load_frame(0, 0, 64, 0);
    n = 0;
    do begin cycle(); n++; end while (!frm_valid && n < 20);
    chk("first_valid_seen", frm_valid, 1);
    chk("latency", cyc_n - pop_cyc, 3);
    wait_idle("single", 200);

    // Error frame drained, then a good one
    rd_tot = 0; valid_tot = 0;
    load_frame(1, 0, 32, 0);
    wait_idle("err", 200);
    chk("err_reads", rd_tot, 32);
    chk("err_no_valid", valid_tot, 0);
    load_frame(0, 2, 16, 5);
    wait_idle("after_err", 200);

    // Backpressure 1,0,0,1
    ready_mode = 1; pat_i = 0;
    rd_tot = 0; acc_tot = 0; ost_on = 1;
    load_frame(0, 1, 10, 0);
    wait_idle("bp", 200);
    chk("bp_accepted", acc_tot, 10);
    ost_on = 0;

    // Boundaries
    ready_mode = 0;
    load_frame(0, 7, 1, 0);
    wait_idle("len1", 100);
    rd_tot = 0;
    load_frame(0, 0, 0, 0);
    wait_idle("len0", 100);
    chk("len0_reads", rd_tot, 0);
    rd_tot = 0; valid_tot = 0;
    load_frame(0, 0, MAX_LEN + 1, 0);
    wait_idle("oversize", 3000);
    chk("oversize_reads", rd_tot, MAX_LEN + 1);
    chk("oversize_no_valid", valid_tot, 0);

    // Back-to-back descriptors
    load_frame(0, 0, 60, 0);
    load_frame(0, 0, 61, 0);
    load_frame(0, 5, 62, 0);
    wait_idle("b2b", 500);

    // Random mix under random backpressure
    ready_mode = 2;
    for (int k = 0; k < 8; k++)
      load_frame(($urandom_range(4) == 0), $urandom_range(7), $urandom_range(40), $urandom_range(15));
    wait_idle("random", 3000);

    // Reset in the middle of a frame
    ready_mode = 0; acc_tot = 0;
    load_frame(0, 3, 64, 0);
    n = 0;
    do begin cycle(); n++; end while (acc_tot < 20 && n < 100);
    chk("mid_reached_byte20", acc_tot, 20);
    pulse_reset();
    check_zero("mid_reset");
    load_frame(0, 4, 8, 0);
    wait_idle("post_reset", 100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rx_frame_reader.md
Name: rx_frame_reader

Overview:
- Switch-side consumer of one MAC port's receive queues (rx_ptr_fifo, rx_data_fifo), clocked on the system clock domain.
- Pops one 20-bit frame descriptor, then reads exactly that many bytes from the data FIFO. Presents them as a ready/valid byte stream with sof/eof markers to the switch ingress arbiter.
- Frames flagged bad, zero-length or oversize are drained silently and counted.

Parameters:
- MAX_LEN, 1518, largest legal frame length in bytes; longer descriptors are drained.
- CNT_W, 16, width of the drop and pass statistics counters (saturating).

Ports:
- clk  in  1  system clock.
- rst_sys  in  1  synchronous reset, active-high.
- ptr_fifo_rd  out  1  pop one descriptor.
- ptr_fifo_dout  in  20  descriptor; valid the cycle after ptr_fifo_rd (standard-mode FIFO).
- ptr_fifo_empty  in  1  descriptor FIFO empty.
- data_fifo_rd  out  1  pop one byte.
- data_fifo_dout  in  8  byte; valid the cycle after data_fifo_rd.
- frm_valid  out  1  output byte valid.
- frm_ready  in  1  consumer accepts the byte when frm_valid && frm_ready.
- frm_data  out  8  frame byte.
- frm_sof  out  1  first byte of the frame.
- frm_eof  out  1  last byte of the frame.
- frm_len  out  12  length of the current frame; stable from sof through eof.
- frm_prio  out  3  priority of the current frame; stable from sof through eof.
- busy  out  1  high in any state except IDLE.
- cnt_pass  out  CNT_W  frames delivered.
- cnt_drop  out  CNT_W  frames drained.

Behaviour:
- Descriptor format:
  - [11:0] length in bytes.
  - [15:12] reserved; ignored.
  - [18:16] priority.
  - [19] error flag, set by the MAC on CRC or alignment failure.
- Reset: every output is 0 and the state is IDLE; reset is synchronous, active-high.
- Reset mid-frame: aborts the frame with no eof. The FIFOs are reset by the same system reset, so no residual bytes remain.
- FSM states and transitions:
  - IDLE: if !ptr_fifo_empty, pulse ptr_fifo_rd for one cycle and go to PLAT.
  - PLAT: capture the descriptor into len_r, prio_r, err_r, and set rem = len.
    - If err, len==0 or len>MAX_LEN: go to DROP; if len==0, go straight to DONE with cnt_drop++.
    - Otherwise go to PASS.
  - PASS: issue data_fifo_rd whenever rem!=0 and (skid occupancy + reads in flight) < 2; rem decrements per read. When rem==0 and the last byte is accepted downstream, go to DONE.
  - DROP: issue data_fifo_rd every cycle while rem!=0; returned bytes are discarded. When rem==0 and the final read has returned, go to DONE.
  - DONE: update counters (cnt_pass++ for PASS, cnt_drop++ otherwise; both saturate at all-ones) and return to IDLE.
    - DONE does not pop a new descriptor in the same cycle: at most one descriptor is in flight.
- Data FIFO: the reader never checks it for empty. The MAC writes the data bytes before the descriptor, so data is guaranteed present.
- Output buffering: a 2-entry skid buffer holds the returned bytes plus sof/eof tags.
  - sof is tagged on byte index 0; eof on byte index len-1.
  - len==1 tags a single byte with both sof and eof.
  - frm_valid is high whenever the buffer is non-empty.
  - Outputs hold unchanged while frm_valid && !frm_ready.
- Throughput: one byte per clock with frm_ready held high.
- Latency: ptr_fifo_empty falling (IDLE) to first frm_valid is 3 cycles:
  - c0: ptr_fifo_rd.
  - c1: descriptor captured in PLAT, first data_fifo_rd issued in the same cycle.
  - c2: byte written into the skid buffer.
  - c3: frm_valid.
- Between frames there are at least 3 idle cycles: DONE, IDLE and PLAT.

Decomposition:
- Package rx_frame_pkg:
  - descriptor field localparams: LEN_LSB=0, LEN_W=12, PRIO_LSB=16, ERR_BIT=19;
  - state encoding: IDLE, PLAT, PASS, DROP, DONE.
- One sub-module, frame_skid_buf: a 2-entry, 10-bit wide (data+sof+eof) ready/valid buffer that outputs its occupancy.

Test Plan:
- Single frame, descriptor 0x0_0040 (len 64, prio 0), frm_ready=1 -> 64 consecutive bytes matching the FIFO contents; sof on byte 0, eof on byte 63, frm_valid exactly 3 cycles after ptr pop; cnt_pass=1.
- Error frame, descriptor 0x8_0020 (len 32, err) -> exactly 32 data_fifo_rd pulses, frm_valid never asserts, cnt_drop=1; the next good frame is delivered intact.
- Backpressure: len 10; frm_ready toggles 1,0,0,1 repeating -> no byte lost or duplicated, data held stable while stalled, data_fifo_rd never leaves more than 2 bytes outstanding.
- Boundaries:
  - len 1 -> one byte with sof=eof=1.
  - len 0 -> no data reads, cnt_drop++.
  - len 1519 with MAX_LEN=1518 -> 1519 bytes drained, cnt_drop++.
- Back-to-back: 3 descriptors queued (len 60, 61, prio 5 len 62) -> 3 frames in order; frm_prio=5 on the third frame; cnt_pass=3.
- Reset: assert rst_sys for 1 cycle at byte 20 of a 64-byte frame -> all outputs 0 the next cycle, state IDLE, counters 0.
